// File: rtl/rc5_key_expand.sv
// rc5_key_expand -- RC5-16 key schedule (16-bit words, 16-byte key, r = 0..31).
//
// On an accepted start the unit captures the 128-bit key and the round count.
// It fills S[0..t-1] with the P16/Q16 progression, where t = 2r+2. It then
// runs 3*max(t,8) mixing iterations over S and L. The finished table is read
// through a registered, one-cycle-latency port.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   start       one-cycle pulse; accepted only while busy = 0
//   num_rounds  round count r (0..31)
//   key         secret key; byte k = key[8k+7:8k]
//   busy        expansion in progress
//   ready       S holds a complete schedule for the last captured key
//   s_raddr     S read address
//   s_rdata     S[s_raddr], registered
//
// Optional build macro RC5_KEY_ZEROIZE_EN:
//   Adds a ZERO state after the last MIX cycle. ZERO wipes L, A and B, and
//   costs one extra cycle of latency.

module rc5_key_expand #(
    parameter int T_MAX = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   num_rounds,
    input  logic [127:0] key,
    output logic         busy,
    output logic         ready,
    input  logic [5:0]   s_raddr,
    output logic [15:0]  s_rdata
);
    localparam logic [15:0] P16 = 16'hB7E1;
    localparam logic [15:0] Q16 = 16'h9E37;

    typedef enum logic [2:0] {IDLE, INIT, MIX, ZERO, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] s_mem [T_MAX];
    logic [15:0] l_mem [8];
    logic [15:0] a_reg, b_reg;
    logic [5:0]  i_idx;
    logic [2:0]  j_idx;
    logic [6:0]  t_reg;
    logic [7:0]  mix_cnt;

    logic        accept;
    logic        i_wrap;
    logic [7:0]  mix_span;
    logic [7:0]  mix_last;
    logic [15:0] init_val;
    logic [15:0] a_new, ab_sum, b_new;

    // Left rotate: the upper half of the doubled word shifted left.
    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] sh);
        logic [31:0] dbl;
        dbl = {x, x} << sh;
        return dbl[31:16];
    endfunction

    // Wait in DONE until busy has fallen before a new start is honoured.
    assign accept   = start && !busy && (state == IDLE || state == DONE);
    assign i_wrap   = (({1'b0, i_idx} + 7'd1) == t_reg);

    // Mixing runs 3*max(t, c) iterations with c = 8 key words.
    assign mix_span = (t_reg < 7'd8) ? 8'd8 : {1'b0, t_reg};
    assign mix_last = mix_span + {mix_span[6:0], 1'b0} - 8'd1;

    assign init_val = (i_idx == 6'd0) ? P16 : s_mem[i_idx - 6'd1] + Q16;
    assign a_new    = rotl16(s_mem[i_idx] + a_reg + b_reg, 4'd3);
    assign ab_sum   = a_new + b_reg;
    assign b_new    = rotl16(l_mem[j_idx] + ab_sum, ab_sum[3:0]);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = INIT;
            INIT:    if (i_wrap) state_next = MIX;
            MIX: begin
                if (mix_cnt == mix_last) begin
`ifdef RC5_KEY_ZEROIZE_EN
                    state_next = ZERO;
`else
                    state_next = DONE;
`endif
                end
            end
            ZERO:    state_next = DONE;
            DONE:    if (accept) state_next = INIT;
            default: state_next = IDLE;
        endcase
    end

    // Control, accumulators and the read port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy    <= 1'b0;
            ready   <= 1'b0;
            s_rdata <= 16'h0000;
            a_reg   <= 16'h0000;
            b_reg   <= 16'h0000;
            i_idx   <= 6'd0;
            j_idx   <= 3'd0;
            t_reg   <= 7'd0;
            mix_cnt <= 8'd0;
        end else begin
            s_rdata <= s_mem[s_raddr];
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        t_reg   <= {1'b0, num_rounds, 1'b0} + 7'd2;
                        a_reg   <= 16'h0000;
                        b_reg   <= 16'h0000;
                        i_idx   <= 6'd0;
                        j_idx   <= 3'd0;
                        mix_cnt <= 8'd0;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                    end else if (state == DONE) begin
                        // The first DONE cycle hands over from busy to ready.
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                INIT: begin
                    i_idx <= i_wrap ? 6'd0 : i_idx + 6'd1;
                end
                MIX: begin
                    a_reg   <= a_new;
                    b_reg   <= b_new;
                    i_idx   <= i_wrap ? 6'd0 : i_idx + 6'd1;
                    j_idx   <= j_idx + 3'd1;
                    mix_cnt <= mix_cnt + 8'd1;
                end
                ZERO: begin
                    a_reg <= 16'h0000;
                    b_reg <= 16'h0000;
                end
                default: ;
            endcase
        end
    end

    // S and L tables. They are not cleared by reset. Writes are blocked while
    // reset is asserted, so a start that coincides with reset cannot load the key.
    always_ff @(posedge clk) begin
        if (rst) begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        for (int k = 0; k < 8; k++) l_mem[k] <= key[16*k +: 16];
                    end
                end
                INIT: s_mem[i_idx] <= init_val;
                MIX: begin
                    s_mem[i_idx] <= a_new;
                    l_mem[j_idx] <= b_new;
                end
                ZERO: begin
                    for (int k = 0; k < 8; k++) l_mem[k] <= 16'h0000;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed bench for rc5_key_expand. A table of {key, rounds, latency,
// re-start point} records is run in a loop. Each run is followed by a full
// S readback compared against a software RC5-16 key-schedule model. The run
// also checks the final internal L, A and B. Hand-written sequences cover
// reset during a run and start coinciding with reset.

module tb_rc5_key_expand;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [4:0]   num_rounds;
    logic [127:0] key;
    logic         busy;
    logic         ready;
    logic [5:0]   s_raddr;
    logic [15:0]  s_rdata;

    always #5 clk = ~clk;

    rc5_key_expand dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_rounds (num_rounds),
        .key        (key),
        .busy       (busy),
        .ready      (ready),
        .s_raddr    (s_raddr),
        .s_rdata    (s_rdata)
    );

`ifdef RC5_KEY_ZEROIZE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    localparam logic [127:0] KSEQ = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] KALT = 128'h0123456789ABCDEFFEDCBA9876543210;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_s [64];
    logic [15:0] m_l [8];
    logic [15:0] m_a, m_b;

    typedef struct {
        logic [127:0] k;
        logic [4:0]   r;
        int           lat;
        int           pulse_at;   // cycle at which a stray start is pulsed (0 = none)
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rol(input logic [15:0] x, input logic [15:0] s);
        int n;
        n = int'(s[3:0]);
        if (n == 0) return x;
        return (x << n) | (x >> (16 - n));
    endfunction

    // Reference RC5-16 key schedule, including the final L/A/B state.
    task automatic model(input logic [127:0] k, input int r);
        int t, n, ii, jj;
        logic [15:0] a, b, ab;
        t = 2 * r + 2;
        n = 3 * ((t > 8) ? t : 8);
        for (int q = 0; q < 8; q++) m_l[q] = k[16*q +: 16];
        m_s[0] = 16'hB7E1;
        for (int q = 1; q < t; q++) m_s[q] = m_s[q-1] + 16'h9E37;
        a = 16'h0; b = 16'h0; ii = 0; jj = 0;
        for (int q = 0; q < n; q++) begin
            a = rol(m_s[ii] + a + b, 16'd3);
            m_s[ii] = a;
            ab = a + b;
            b = rol(m_l[jj] + a + b, ab);
            m_l[jj] = b;
            ii = (ii + 1) % t;
            jj = (jj + 1) % 8;
        end
        m_a = a;
        m_b = b;
`ifdef RC5_KEY_ZEROIZE_EN
        for (int q = 0; q < 8; q++) m_l[q] = 16'h0;
        m_a = 16'h0;
        m_b = 16'h0;
`endif
    endtask

    task automatic launch(input string nm, input logic [127:0] k, input logic [4:0] r);
        key = k;
        num_rounds = r;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the inputs so a late capture would corrupt the schedule.
        key = ~k;
        num_rounds = ~r;
        chk({nm, " busy after start"}, 32'(busy), 32'd1);
        chk({nm, " ready after start"}, 32'(ready), 32'd0);
    endtask

    task automatic wait_ready(input string nm, input int exp_lat, input int pulse_at);
        int cnt;
        int both;
        cnt = 0;
        both = 0;
        while (!ready && cnt < 400) begin
            @(posedge clk); #1;
            cnt++;
            if (busy && ready) both++;
            start = (cnt == pulse_at);
        end
        start = 1'b0;
        chk({nm, " latency"}, 32'(cnt), 32'(exp_lat));
        chk({nm, " busy&ready overlap"}, 32'(both), 32'd0);
        @(posedge clk); #1;
        chk({nm, " ready held"}, 32'(ready), 32'd1);
        chk({nm, " busy low"}, 32'(busy), 32'd0);
    endtask

    task automatic check_s(input string nm, input logic [127:0] k, input int r);
        int t;
        t = 2 * r + 2;
        model(k, r);
        for (int q = 0; q < t; q++) begin
            s_raddr = 6'(q);
            @(posedge clk); #1;
            chk($sformatf("%s S[%0d]", nm, q), 32'(s_rdata), 32'(m_s[q]));
        end
        for (int q = 0; q < 8; q++)
            chk($sformatf("%s L[%0d]", nm, q), 32'(dut.l_mem[q]), 32'(m_l[q]));
        chk({nm, " A"}, 32'(dut.a_reg), 32'(m_a));
        chk({nm, " B"}, 32'(dut.b_reg), 32'(m_b));
    endtask

    initial begin
        vecs[0] = '{k: 128'h0, r: 5'd12, lat: 105 + EXTRA, pulse_at: 0};
        vecs[1] = '{k: KSEQ,   r: 5'd0,  lat: 27 + EXTRA,  pulse_at: 0};
        vecs[2] = '{k: KSEQ,   r: 5'd31, lat: 257 + EXTRA, pulse_at: 0};
        vecs[3] = '{k: 128'h0, r: 5'd12, lat: 105 + EXTRA, pulse_at: 10};
        vecs[4] = '{k: KALT,   r: 5'd3,  lat: 8 + 24 + 1 + EXTRA, pulse_at: 8 + 24 + EXTRA};
        vecs[5] = '{k: KALT,   r: 5'd5,  lat: 12 + 36 + 1 + EXTRA, pulse_at: 0};

        rst = 1'b0;
        start = 1'b0;
        key = 128'h0;
        num_rounds = 5'd0;
        s_raddr = 6'd0;

        // Reset state.
        @(posedge clk); #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset s_rdata", 32'(s_rdata), 32'd0);
        rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            string nm;
            nm = $sformatf("v%0d", v);
            launch(nm, vecs[v].k, vecs[v].r);
            wait_ready(nm, vecs[v].lat, vecs[v].pulse_at);
            check_s(nm, vecs[v].k, int'(vecs[v].r));
        end

        // Reset part-way through an r=12 run, then a clean restart.
        launch("abort", KALT, 5'd12);
        repeat (49) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        chk("abort idle busy", 32'(busy), 32'd0);
        launch("rerun", KSEQ, 5'd12);
        wait_ready("rerun", 105 + EXTRA, 0);
        check_s("rerun", KSEQ, 12);

        // start coinciding with reset: reset wins and drops ready.
        key = KALT;
        num_rounds = 5'd2;
        start = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        chk("start+reset busy", 32'(busy), 32'd0);
        chk("start+reset ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        chk("start+reset stays idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
